// File: rtl/qz_deser_fifo_pkg.sv
// Shared definitions for the QZ deserializer: width helpers and reset values.
package qz_deser_fifo_pkg;

   // Widest packed word the collector supports.
   localparam int MAX_WIDTH = 16;

   // LEVEL must count 0..DEPTH, so it needs one bit beyond the pointer width.
   localparam int LVL_EXTRA_BITS = 1;

   // Value loaded into the collector shift register and FIFO storage on reset.
   localparam logic [MAX_WIDTH-1:0] SR_RST_VAL = 16'h0000;

   // FIFO pointer width for a power-of-two depth.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy counter width for a given depth.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + LVL_EXTRA_BITS;
   endfunction

   // Partial-word bit counter width for a given word width.
   function automatic int part_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/qz_deser_fifo_sync_fifo_core.sv
// Synchronous FIFO storage with occupancy count and sticky overflow.
// A push into a full FIFO is still accepted when the head is popped on the
// same edge; otherwise it is dropped and the overflow flag latches.
module sync_fifo_core
   import qz_deser_fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      rdy,
   output logic [WIDTH-1:0]          rdata,
   output logic                      valid,
   output logic [lvl_w(DEPTH)-1:0]   level,
   output logic                      ovf
);

   localparam int AW = ptr_w(DEPTH);
   localparam int LW = lvl_w(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
   localparam logic [LW-1:0] LVL_ZERO = LW'(1'b0);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [LW-1:0]    level_r;
   logic             ovf_r;

   logic             pop_s;
   logic             accept_s;
   logic             drop_s;
   logic [LW-1:0]    level_nxt_s;

   // Decide pop/accept/drop and the next occupancy from registered state.
   always_comb begin
      pop_s       = 1'b0;
      accept_s    = 1'b0;
      drop_s      = 1'b0;
      level_nxt_s = level_r;
      pop_s    = (level_r != LVL_ZERO) && rdy;
      accept_s = push && ((level_r != LVL_FULL) || pop_s);
      drop_s   = push && !accept_s;
      case ({accept_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Storage, pointers, occupancy and sticky overflow register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= SR_RST_VAL[WIDTH-1:0];
         end
         rd_ptr_r <= PTR_ZERO;
         wr_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
         ovf_r    <= 1'b0;
      end else begin
         if (accept_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         level_r <= level_nxt_s;
         ovf_r   <= ovf_r | drop_s;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign valid = (level_r != LVL_ZERO);
   assign level = level_r;
   assign ovf   = ovf_r;

endmodule

// File: rtl/qz_deser_fifo.sv
// Serial-to-parallel collector for the LUT+FF macro's QZ output.
// Samples are packed LSB-first into WIDTH-bit words and queued for a
// valid/ready consumer. All outputs come from registered state.
module qz_deser_fifo
   import qz_deser_fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       D,
   input  logic                       EN,
   input  logic                       FLUSH,
   input  logic                       OREADY,
   output logic [WIDTH-1:0]           ODATA,
   output logic                       OVALID,
   output logic [lvl_w(DEPTH)-1:0]    LEVEL,
   output logic [part_w(WIDTH)-1:0]   PART,
   output logic                       OVF
);

   localparam int PW = part_w(WIDTH);
   localparam logic [PW-1:0] PART_ZERO = PW'(1'b0);
   localparam logic [PW-1:0] PART_LAST = PW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_r;
   logic [PW-1:0]    part_r;

   logic [WIDTH-1:0] sr_with_s;
   logic [PW-1:0]    part_with_s;
   logic             full_s;
   logic             flush_push_s;
   logic             push_s;

   // Fold this cycle's sample into the partial word and decide whether to push.
   always_comb begin
      sr_with_s    = sr_r;
      part_with_s  = part_r;
      full_s       = 1'b0;
      flush_push_s = 1'b0;
      push_s       = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (EN && (part_r == PW'(i))) begin
            sr_with_s[i] = D;
         end else begin
            sr_with_s[i] = sr_r[i];
         end
      end
      part_with_s = part_r + {{(PW-1){1'b0}}, EN};
      full_s      = EN && (part_r == PART_LAST);
      // A flush alongside a completing bit yields only the full word.
      flush_push_s = FLUSH && !full_s && (part_with_s != PART_ZERO);
      push_s       = full_s || flush_push_s;
   end

   // Collector state: restart empty after any push, otherwise keep accumulating.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sr_r   <= SR_RST_VAL[WIDTH-1:0];
         part_r <= PART_ZERO;
      end else if (push_s) begin
         sr_r   <= SR_RST_VAL[WIDTH-1:0];
         part_r <= PART_ZERO;
      end else begin
         sr_r   <= sr_with_s;
         part_r <= part_with_s;
      end
   end

   sync_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_s),
      .wdata (sr_with_s),
      .rdy   (OREADY),
      .rdata (ODATA),
      .valid (OVALID),
      .level (LEVEL),
      .ovf   (OVF)
   );

   assign PART = part_r;

endmodule
